// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage load/store engine: width codes, access
// size codes, FSM state encodings and the alignment rule.
package mem_access_unit_pkg;

  localparam int XLEN_32b = 1;
  localparam int XLEN_64b = 2;

  localparam logic [1:0] F3_B = 2'b00;
  localparam logic [1:0] F3_H = 2'b01;
  localparam logic [1:0] F3_W = 2'b10;
  localparam logic [1:0] F3_D = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr_lo);
    case (size)
      F3_B:    return 1'b1;
      F3_H:    return ~addr_lo[0];
      F3_W:    return addr_lo[1:0] == 2'b00;
      default: return addr_lo == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load data formatter: selects the addressed bytes of a full
// bus word and sign- or zero-extends them to DW bits.
module load_formatter
  import mem_access_unit_pkg::*;
#(
  parameter int DW = 64,
  localparam int OW = $clog2(DW / 8)
) (
  input  logic [DW-1:0] rdata,
  input  logic [OW-1:0] offset,
  input  logic [2:0]    f3,
  output logic [DW-1:0] result
);

  logic [DW-1:0] shifted;
  logic [DW-1:0] size_mask;
  logic          sign_bit;

  assign shifted = rdata >> {offset, 3'b000};

  generate
    for (genvar gi = 0; gi < DW; gi++) begin : g_mask
      assign size_mask[gi] = (gi < (8 << f3[1:0]));
    end
  endgenerate

  always_comb begin
    sign_bit = 1'b0;
    case (f3[1:0])
      F3_B:    sign_bit = shifted[7];
      F3_H:    sign_bit = shifted[15];
      F3_W:    sign_bit = shifted[31];
      default: sign_bit = 1'b0;
    endcase
  end

  // Upper bits come from the sign bit unless f3[2] requests zero extension.
  assign result = (shifted & size_mask) | ({DW{sign_bit & ~f3[2]}} & ~size_mask);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/ack bus transaction per access, stalls
// the pipeline while busy, formats load data and reports misaligned/faulting accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = XLEN_64b,
  localparam int DW = 1 << (XLEN + 4),
  localparam int NB = DW / 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid_m,
  input  logic          i_flush_m,
  input  logic          i_mem_rd_m,
  input  logic          i_mem_wr_m,
  input  logic [2:0]    i_f3_m,
  input  logic [DW-1:0] i_addr_m,
  input  logic [DW-1:0] i_wdata_m,
  output logic          o_stall,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [DW-1:0] o_bus_addr,
  output logic [NB-1:0] o_bus_be,
  output logic [DW-1:0] o_bus_wdata,
  input  logic          i_bus_ack,
  input  logic [DW-1:0] i_bus_rdata,
  input  logic          i_bus_err,
  output logic [DW-1:0] o_mem_out_m,
  output logic          o_misaligned,
  output logic          o_access_fault,
  output logic [DW-1:0] o_fault_addr
);

  localparam int OW = $clog2(NB);

  logic [1:0]    state_reg, state_next;
  logic [DW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [NB-1:0] be_reg;
  logic [2:0]    f3_reg;
  logic          we_reg;
  logic          err_reg;
  logic          flushed_reg;
  logic [DW-1:0] mem_out_reg;

  logic [1:0]    size;
  logic          illegal;
  logic          aligned;
  logic          req_ok;
  logic          start;
  logic          misaligned;
  logic          illegal_fault;
  logic          busy;
  logic          done_fault;
  logic          suppress;
  logic [NB-1:0] size_be;
  logic [NB-1:0] be_next;
  logic [OW-1:0] lane_mask;
  logic [DW-1:0] wdata_next;
  logic [DW-1:0] load_result;

  assign size    = i_f3_m[1:0];
  assign illegal = (i_f3_m == 3'b111) || ((size == F3_D) && (DW == 32));
  assign aligned = is_aligned(size, i_addr_m[2:0]);
  assign busy    = (state_reg == ST_BUSY);

  assign req_ok        = ~i_rst & (state_reg == ST_IDLE) & i_valid_m & ~i_flush_m
                         & (i_mem_rd_m | i_mem_wr_m);
  assign start         = req_ok & ~illegal & aligned;
  assign misaligned    = req_ok & ~illegal & ~aligned;
  assign illegal_fault = req_ok & illegal;
  assign done_fault    = (state_reg == ST_DONE) & err_reg;

  // A flush seen at any point in BUSY (including the ack cycle) kills the result.
  assign suppress = flushed_reg | i_flush_m;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_be
      assign size_be[gi] = (gi < (1 << size));
    end
  endgenerate

  assign be_next = size_be << i_addr_m[OW-1:0];

  always_comb begin
    lane_mask = '0;
    case (size)
      F3_B:    lane_mask = '0;
      F3_H:    lane_mask = OW'(1);
      F3_W:    lane_mask = OW'(3);
      default: lane_mask = '1;
    endcase
  end

  // Store data is replicated so that every lane group carries the sized value.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      localparam logic [OW-1:0] LANE = OW'(gi);
      assign wdata_next[8*gi +: 8] = i_wdata_m[{(LANE & lane_mask), 3'b000} +: 8];
    end
  endgenerate

  load_formatter #(
    .DW (DW)
  ) u_load_formatter (
    .rdata  (i_bus_rdata),
    .offset (addr_reg[OW-1:0]),
    .f3     (f3_reg),
    .result (load_result)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_BUSY;
      ST_BUSY: if (i_bus_ack) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      be_reg      <= '0;
      f3_reg      <= '0;
      we_reg      <= 1'b0;
      err_reg     <= 1'b0;
      flushed_reg <= 1'b0;
      mem_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        addr_reg    <= i_addr_m;
        wdata_reg   <= wdata_next;
        be_reg      <= be_next;
        f3_reg      <= i_f3_m;
        we_reg      <= i_mem_wr_m;
        err_reg     <= 1'b0;
        flushed_reg <= 1'b0;
      end
      if (busy) begin
        if (i_flush_m) flushed_reg <= 1'b1;
        if (i_bus_ack) begin
          err_reg <= i_bus_err & ~suppress;
          if (!suppress) begin
            if (i_bus_err) mem_out_reg <= '0;
            else if (!we_reg) mem_out_reg <= load_result;
          end
        end
      end
    end
  end

  assign o_stall        = start | busy;
  assign o_bus_req      = busy;
  assign o_bus_we       = we_reg;
  assign o_bus_addr     = {addr_reg[DW-1:OW], {OW{1'b0}}};
  assign o_bus_be       = be_reg;
  assign o_bus_wdata    = wdata_reg;
  assign o_mem_out_m    = mem_out_reg;
  assign o_misaligned   = misaligned;
  assign o_access_fault = illegal_fault | done_fault;
  assign o_fault_addr   = (misaligned | illegal_fault) ? i_addr_m :
                          done_fault                   ? addr_reg : '0;

endmodule
